// File: rtl/move_pkg.sv
// Shared direction codes, FSM state encoding and key-vector helpers for move_cmd_gen.
// Pure declarations, no timing.
// Key vector bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right.
package move_pkg;

    // Same codes as the shortest-path dir output so player can share decode logic.
    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } move_state_t;

    // Highest-priority set key (up > down > left > right), DIR_NONE if none.
    function automatic logic [2:0] prio_dir(input logic [3:0] keys);
        logic [2:0] dir;
        dir = DIR_NONE;
        if (keys[KEY_UP])          dir = DIR_UP;
        else if (keys[KEY_DOWN])   dir = DIR_DOWN;
        else if (keys[KEY_LEFT])   dir = DIR_LEFT;
        else if (keys[KEY_RIGHT])  dir = DIR_RIGHT;
        return dir;
    endfunction

    // Level of the key that corresponds to a direction code.
    function automatic logic key_of_dir(input logic [3:0] keys, input logic [2:0] dir);
        logic lvl;
        case (dir)
            DIR_UP:    lvl = keys[KEY_UP];
            DIR_DOWN:  lvl = keys[KEY_DOWN];
            DIR_LEFT:  lvl = keys[KEY_LEFT];
            DIR_RIGHT: lvl = keys[KEY_RIGHT];
            default:   lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO for step commands with flush and a registered drop pulse.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: i_clk, i_rst (sync active-low), i_flush, i_push/i_push_dat, i_pop,
//        o_head_dat, o_full, o_empty, o_level, o_overflow (1-clk drop pulse).
module move_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_drop;

    assign o_full   = (r_level == LW'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign w_pop_ok = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign w_drop    = i_push && o_full && !w_pop_ok;

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_overflow <= w_drop;
        end
    end

    // Storage needs no reset: entries are only read when counted in r_level.
    always_ff @(posedge i_clk) begin
        if (i_rst && !i_flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns held direction levels into step commands (press + optional auto-repeat) queued for player.
// Latency: input rise to o_move_valid is 2 clk (one input register, one FIFO write).
// Backpressure: steps wait in the FIFO on !i_move_ready; a step arriving at a full FIFO is dropped with o_overflow.
// Build option: MOVE_AUTO_REPEAT_EN enables the DELAY/REPEAT auto-repeat FSM; undefined = one step per press.
// Ports: i_clk, i_rst (sync active-low), i_tick (rate strobe), i_up_in/i_down_in/i_left_in/i_right_in (levels),
//        i_player_alive (0 flushes and mutes), i_move_ready; o_move_valid, o_move_dir, o_fifo_level, o_overflow.
module move_cmd_gen
    import move_pkg::*;
#(
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_tick,
    input  logic                          i_up_in,
    input  logic                          i_down_in,
    input  logic                          i_left_in,
    input  logic                          i_right_in,
    input  logic                          i_player_alive,
    input  logic                          i_move_ready,
    output logic                          o_move_valid,
    output logic [2:0]                    o_move_dir,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow
);

    logic [3:0] w_keys;
    logic [3:0] r_key_q;
    logic [3:0] r_key_qq;
    logic       r_armed;

    logic [3:0] w_rise;
    logic [2:0] w_rise_dir;
    logic       w_push;
    logic [2:0] w_push_dir;

    logic [2:0] w_head_dat;
    logic       w_empty;
    logic       w_pop;
    logic       w_unused_full;

    assign w_keys = {i_right_in, i_left_in, i_down_in, i_up_in};

    // r_armed drops while the player is dead and only re-arms once every key
    // reads released, so a key held across a death cannot fire on revival.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_key_q  <= '0;
            r_key_qq <= '0;
            r_armed  <= 1'b1;
        end else begin
            r_key_q  <= w_keys;
            r_key_qq <= r_key_q;
            if (!i_player_alive)     r_armed <= 1'b0;
            else if (r_key_q == '0)  r_armed <= 1'b1;
        end
    end

    assign w_rise     = r_key_q & ~r_key_qq & {4{r_armed && i_player_alive}};
    assign w_rise_dir = prio_dir(w_rise);

`ifdef MOVE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    move_state_t      r_state;
    move_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_act_dir;
    logic [2:0]       w_act_nxt;
    logic [2:0]       w_held_dir;
    logic             w_act_held;
    logic             w_cnt_last;

    assign w_held_dir = prio_dir(r_key_q);
    assign w_act_held = key_of_dir(r_key_q, r_act_dir);
    assign w_cnt_last = (r_state == ST_DELAY) ? (r_cnt == DELAY_LAST) : (r_cnt == PERIOD_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_act_dir <= DIR_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_act_dir <= w_act_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_act_nxt   = r_act_dir;
        w_push      = 1'b0;
        w_push_dir  = r_act_dir;

        if (!i_player_alive) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_act_nxt   = DIR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_rise) begin
                        w_push      = 1'b1;
                        w_push_dir  = w_rise_dir;
                        w_act_nxt   = w_rise_dir;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (|w_rise) begin
                        // Newest press takes over the repeat.
                        w_push      = 1'b1;
                        w_push_dir  = w_rise_dir;
                        w_act_nxt   = w_rise_dir;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DELAY;
                    end else if (!w_act_held) begin
                        // Fall back to a still-held key silently; it restarts the full delay.
                        w_cnt_nxt = '0;
                        if (|r_key_q) begin
                            w_act_nxt   = w_held_dir;
                            w_state_nxt = ST_DELAY;
                        end else begin
                            w_act_nxt   = DIR_NONE;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (i_tick) begin
                        if (w_cnt_last) begin
                            w_push      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_act_nxt   = DIR_NONE;
                end
            endcase
        end
    end
`else
    logic w_unused_cfg;

    // One step per accepted press; timing configuration and tick have no role here.
    assign w_push       = |w_rise;
    assign w_push_dir   = w_rise_dir;
    assign w_unused_cfg = i_tick ^ (REPEAT_DELAY != REPEAT_PERIOD) ^ (CNT_W > 1);
`endif

    assign w_pop = !w_empty && i_move_ready;

    move_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (!i_player_alive),
        .i_push     (w_push),
        .i_push_dat (w_push_dir),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_unused_full),
        .o_empty    (w_empty),
        .o_level    (o_fifo_level),
        .o_overflow (o_overflow)
    );

    assign o_move_valid = !w_empty;
    assign o_move_dir   = w_empty ? DIR_NONE : w_head_dat;

endmodule

// File: tb/tb_move_cmd_gen.sv
module tb_move_cmd_gen;
    import move_pkg::*;

    localparam int RD = 16;
    localparam int RP = 4;
`ifdef MOVE_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       up    = 1'b0;
    logic       down  = 1'b0;
    logic       left  = 1'b0;
    logic       right = 1'b0;
    logic       alive = 1'b1;
    logic       ready = 1'b0;
    logic       o_move_valid;
    logic [2:0] o_move_dir;
    logic [2:0] o_fifo_level;
    logic       o_overflow;

    always #5 clk = ~clk;

    move_cmd_gen #(
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .FIFO_DEPTH    (4),
        .CNT_W         (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_tick         (tick),
        .i_up_in        (up),
        .i_down_in      (down),
        .i_left_in      (left),
        .i_right_in     (right),
        .i_player_alive (alive),
        .i_move_ready   (ready),
        .o_move_valid   (o_move_valid),
        .o_move_dir     (o_move_dir),
        .o_fifo_level   (o_fifo_level),
        .o_overflow     (o_overflow)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    bit   mon_en   = 1'b0;
    int   ovf_cnt  = 0;
    int   gcount   = 0;
    int   tick_per = 0;

    // Reference model state: keys as seen one and two edges ago, active key, ticks since activation.
    bit         model_en = 1'b0;
    bit [3:0]   m_k1 = '0;
    bit [3:0]   m_k2 = '0;
    logic [2:0] m_act = DIR_NONE;
    int         m_tcnt = 0;

    // Transfers are recorded at the negedge before the edge that pops them.
    always @(negedge clk) begin
        if (o_overflow) ovf_cnt++;
        if (mon_en && o_move_valid && ready) got_q.push_back(o_move_dir);
    end

    function automatic logic [2:0] spec_prio(input bit [3:0] k);
        logic [2:0] d;
        d = DIR_NONE;
        if (k[3]) d = DIR_RIGHT;
        if (k[2]) d = DIR_LEFT;
        if (k[1]) d = DIR_DOWN;
        if (k[0]) d = DIR_UP;
        return d;
    endfunction

    // Press emits a step; auto-repeat emits when the tick count since activation hits
    // REPEAT_DELAY, then every REPEAT_PERIOD; releasing the active key hands over silently.
    task automatic model_step();
        bit [3:0] k_now;
        bit [3:0] r;
        k_now = {right, left, down, up};
        r = m_k1 & ~m_k2;
        if (r != 0) begin
            m_act  = spec_prio(r);
            m_tcnt = 0;
            exp_q.push_back(m_act);
        end else if (m_act != DIR_NONE && !m_k1[int'(m_act) - 1]) begin
            m_tcnt = 0;
            m_act  = (m_k1 != 0) ? spec_prio(m_k1) : DIR_NONE;
        end else if (m_act != DIR_NONE && tick) begin
            m_tcnt++;
            if (AUTO && (m_tcnt == RD || (m_tcnt > RD && (m_tcnt - RD) % RP == 0)))
                exp_q.push_back(m_act);
        end
        m_k2 = m_k1;
        m_k1 = k_now;
    endtask

    task automatic cyc(input bit [3:0] k);
        @(posedge clk);
        if (model_en) model_step();
        #1;
        {right, left, down, up} = k;
        gcount++;
        tick = (tick_per > 0) && (gcount % tick_per == 0);
    endtask

    task automatic run(input bit [3:0] k, input int n);
        for (int i = 0; i < n; i++) cyc(k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alive = 1'b1; ready = 1'b0; tick_per = 0;
        {right, left, down, up} = 4'hF;
        run(4'hF, 3);
        @(negedge clk);
        checks++; if (o_move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_move_valid); end
        checks++; if (o_move_dir !== DIR_NONE) begin errors++; $display("FAIL reset_dir got %0d want 0", o_move_dir); end
        checks++; if (o_fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", o_fifo_level); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", o_overflow); end
        rst_n = 1'b1; ready = 1'b1; got_q.delete(); mon_en = 1'b1;
        cyc(4'hF);
        @(negedge clk);
        checks++; if (o_move_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b want 0", o_move_valid); end
        checks++; if (o_fifo_level !== 3'd0) begin errors++; $display("FAIL post_reset_level got %0d want 0", o_fifo_level); end
        run(4'h0, 10);
        @(negedge clk);
        checks++; if (got_q.size() != 1 || got_q[0] !== DIR_UP) begin errors++; $display("FAIL post_reset_step got n=%0d want one UP", got_q.size()); end
        checks++; if (o_fifo_level !== 3'd0) begin errors++; $display("FAIL post_reset_drain got %0d want 0", o_fifo_level); end
    endtask

    task automatic test_single_press();
        got_q.delete(); tick_per = 4; gcount = 0;
        run(4'h0, 4);
        cyc(4'b0001);
        cyc(4'b0001);
        @(negedge clk);
        checks++; if (o_move_valid !== 1'b0) begin errors++; $display("FAIL press_lat_1clk valid got %0b want 0", o_move_valid); end
        cyc(4'b0001);
        @(negedge clk);
        checks++; if (o_move_valid !== 1'b1 || o_move_dir !== DIR_UP) begin errors++; $display("FAIL press_lat_2clk got v=%0b d=%0d want v=1 d=1", o_move_valid, o_move_dir); end
        run(4'b0001, 8);
        run(4'h0, 8);
        @(negedge clk);
        checks++; if (got_q.size() != 1 || got_q[0] !== DIR_UP) begin errors++; $display("FAIL single_press_count got n=%0d want one UP", got_q.size()); end
    endtask

    task automatic test_auto_repeat();
        got_q.delete(); exp_q.delete();
        m_k1 = '0; m_k2 = '0; m_act = DIR_NONE; m_tcnt = 0; model_en = 1'b1;
        tick_per = 4; gcount = 0;
        run(4'b1000, 104);
        run(4'h0, 10);
        model_en = 1'b0;
        @(negedge clk);
        checks++; if (got_q.size() != (AUTO ? 4 : 1)) begin errors++; $display("FAIL repeat_count got %0d want %0d", got_q.size(), AUTO ? 4 : 1); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL repeat_model_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== DIR_RIGHT) begin errors++; $display("FAIL repeat_dir[%0d] got %0d want 4", i, got_q[i]); end
        end
    endtask

    task automatic test_overflow();
        bit [3:0]   presses [5];
        logic [2:0] order   [4];
        presses = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        order   = '{DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
        cyc(4'h0);
        ready = 1'b0; tick_per = 0; got_q.delete(); ovf_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run(presses[i], 2);
            run(4'h0, 2);
        end
        run(4'h0, 4);
        @(negedge clk);
        checks++; if (o_fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", o_fifo_level); end
        checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL overflow_pulses got %0d want 1", ovf_cnt); end
        checks++; if (o_move_valid !== 1'b1 || o_move_dir !== DIR_UP) begin errors++; $display("FAIL stall_head got v=%0b d=%0d want v=1 d=1", o_move_valid, o_move_dir); end
        cyc(4'h0);
        ready = 1'b1;
        run(4'h0, 8);
        @(negedge clk);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL drain_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== order[i]) begin errors++; $display("FAIL drain_order[%0d] got %0d want %0d", i, got_q[i], order[i]); end
        end
        checks++; if (o_move_valid !== 1'b0 || o_fifo_level !== 3'd0) begin errors++; $display("FAIL drain_empty got v=%0b l=%0d want 0 0", o_move_valid, o_fifo_level); end
    endtask

    task automatic test_priority();
        logic [2:0] want[$];
        got_q.delete(); tick_per = 0;
        run(4'b0101, 6);
        @(negedge clk);
        checks++; if (got_q.size() != 1 || got_q[0] !== DIR_UP) begin errors++; $display("FAIL same_clk_prio got n=%0d want one UP", got_q.size()); end
        run(4'b0100, 4);
        @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL release_no_push got %0d want 1", got_q.size()); end
        tick_per = 4; gcount = 0;
        run(4'b0100, 63);
        @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL delay_15_ticks got %0d want 1", got_q.size()); end
        run(4'b0100, 7);
        @(negedge clk);
        want.push_back(DIR_UP);
        if (AUTO) want.push_back(DIR_LEFT);
        checks++; if (got_q.size() != want.size()) begin errors++; $display("FAIL handover_count got %0d want %0d", got_q.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL handover_dir[%0d] got %0d want %0d", i, got_q[i], want[i]); end
        end
        tick_per = 0;
        run(4'h0, 6);
    endtask

    task automatic test_alive();
        cyc(4'h0);
        ready = 1'b0; tick_per = 0; got_q.delete();
        run(4'b0001, 2); run(4'h0, 2);
        run(4'b0010, 2); run(4'h0, 2);
        run(4'b0100, 4);
        @(negedge clk);
        checks++; if (o_fifo_level !== 3'd3) begin errors++; $display("FAIL pre_flush_level got %0d want 3", o_fifo_level); end
        cyc(4'b0100);
        alive = 1'b0;
        cyc(4'b0100);
        @(negedge clk);
        checks++; if (o_fifo_level !== 3'd0 || o_move_valid !== 1'b0) begin errors++; $display("FAIL flush got l=%0d v=%0b want 0 0", o_fifo_level, o_move_valid); end
        cyc(4'b0100);
        alive = 1'b1; ready = 1'b1; tick_per = 4; gcount = 0;
        run(4'b0100, 80);
        @(negedge clk);
        checks++; if (got_q.size() != 0 || o_fifo_level !== 3'd0) begin errors++; $display("FAIL revive_held got n=%0d l=%0d want 0 0", got_q.size(), o_fifo_level); end
        tick_per = 0;
        run(4'h0, 4);
        run(4'b0100, 6);
        run(4'h0, 6);
        @(negedge clk);
        checks++; if (got_q.size() != 1 || got_q[0] !== DIR_LEFT) begin errors++; $display("FAIL revive_repress got n=%0d want one LEFT", got_q.size()); end
    endtask

    task automatic test_random();
        bit [3:0] k;
        int idx;
        ready = 1'b1; tick_per = 3; gcount = 0; ovf_cnt = 0;
        for (int it = 0; it < 4; it++) begin
            got_q.delete(); exp_q.delete();
            m_k1 = '0; m_k2 = '0; m_act = DIR_NONE; m_tcnt = 0; model_en = 1'b1;
            k = '0;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    idx = $urandom_range(0, 3);
                    k[idx] = ~k[idx];
                end
                cyc(k);
            end
            run(4'h0, 10);
            model_en = 1'b0;
            @(negedge clk);
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len it=%0d got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_step it=%0d i=%0d got %0d want %0d", it, i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL rand_overflow got %0d want 0", ovf_cnt); end
        tick_per = 0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_overflow();
        test_priority();
        test_alive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
